// File: rtl/patch_reducer_dispatcher.sv
// patch_reducer_dispatcher
//
// Schedules patch-reduction jobs onto a pool of N_REDUCER PatchRowReducer
// instances and drains their finished sums through one round-robin result
// port.
//
// Ports
//   CLK, RESET        clock; synchronous active-high reset
//   req_valid/ready   request handshake (req_ready is combinational)
//   req_patch_num, req_row, req_col, req_sum   request payload
//   cur_row           row currently streaming to the reducers
//   red_available     per-reducer available flags
//   red_done          per-reducer one-cycle done pulses
//   red_patch_num     per-reducer patch numbers, reducer i at slice i
//   red_sum           per-reducer sums, reducer i at slice i
//   red_init          one-hot registered init strobe
//   conf_*            registered shared configuration bus
//   res_valid/ack     result handshake
//   res_patch_num, res_sum   result payload
//   n_late            saturating count of dropped late requests
//   busy              any reducer owned or a result waiting
//
// Optional feature macro: DISPATCH_LATE_DROP_EN
//   defined     -> requests with req_row < cur_row are accepted and dropped,
//                  counted in n_late
//   not defined -> every request is dispatched, n_late is tied to 0

module patch_reducer_dispatcher #(
  parameter int N_REDUCER  = 4,
  parameter int N_PATCH    = 16,
  parameter int N_ROW_SIZE = 11,
  parameter int N_COL_SIZE = 11,
  parameter int FP_SIZE    = 32,
  parameter int DELAY      = 1
) (
  input  logic                               CLK,
  input  logic                               RESET,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [$clog2(N_PATCH)-1:0]         req_patch_num,
  input  logic [N_ROW_SIZE-1:0]              req_row,
  input  logic [N_COL_SIZE-1:0]              req_col,
  input  logic [FP_SIZE-1:0]                 req_sum,
  input  logic [N_ROW_SIZE-1:0]              cur_row,
  input  logic [N_REDUCER-1:0]               red_available,
  input  logic [N_REDUCER-1:0]               red_done,
  input  logic [N_REDUCER*$clog2(N_PATCH)-1:0] red_patch_num,
  input  logic [N_REDUCER*FP_SIZE-1:0]       red_sum,
  output logic [N_REDUCER-1:0]               red_init,
  output logic [$clog2(N_PATCH)-1:0]         conf_patch_num,
  output logic [N_ROW_SIZE-1:0]              conf_row,
  output logic [N_COL_SIZE-1:0]              conf_col,
  output logic [FP_SIZE-1:0]                 conf_sum,
  output logic                               res_valid,
  input  logic                               res_ack,
  output logic [$clog2(N_PATCH)-1:0]         res_patch_num,
  output logic [FP_SIZE-1:0]                 res_sum,
  output logic [15:0]                        n_late,
  output logic                               busy
);

  localparam int PW = $clog2(N_PATCH);
  localparam int RW = $clog2(N_REDUCER);

  logic [N_REDUCER-1:0] owned;
  logic [N_REDUCER-1:0] pending;
  logic [RW-1:0]        rr;
  logic [RW-1:0]        res_idx;

  logic [N_REDUCER-1:0] free;
  logic                 accept;
  logic                 late;
  logic                 dispatch;
  logic [RW-1:0]        disp_idx;
  logic [N_REDUCER-1:0] disp_mask;

  logic                 ack;
  logic                 load;
  logic [RW-1:0]        ack_next_idx;
  logic [RW-1:0]        search_start;
  logic [N_REDUCER-1:0] ack_mask;
  logic [N_REDUCER-1:0] cand_mask;
  logic                 cand_found;
  logic [RW-1:0]        cand_idx;

  logic [31:0]          unused_delay;
  assign unused_delay = DELAY;

  // owned keeps a reducer out of the free set from init until its result is
  // acked, covering the lag before its available flag falls.
  assign free      = red_available & ~owned;
  assign req_ready = |free;
  assign accept    = req_valid & req_ready;
  assign dispatch  = accept & ~late;
  assign busy      = (|owned) | res_valid;

  // Lowest-index free reducer wins the dispatch.
  always_comb begin
    disp_idx = '0;
    for (int i = N_REDUCER - 1; i >= 0; i--) begin
      if (free[i]) disp_idx = RW'(i);
    end
  end

  assign disp_mask = dispatch ? (N_REDUCER'(1) << disp_idx) : '0;

  assign ack          = res_valid & res_ack;
  assign load         = ~res_valid | ack;
  assign ack_next_idx = (res_idx == RW'(N_REDUCER - 1)) ? '0 : res_idx + 1'b1;
  assign ack_mask     = ack ? (N_REDUCER'(1) << res_idx) : '0;

  // When draining and reloading in the same cycle, the search starts where
  // the pointer is about to move, and the entry being drained is excluded
  // since its pending bit only clears at this edge.
  assign search_start = ack ? ack_next_idx : rr;
  assign cand_mask    = pending & ~ack_mask;

  always_comb begin
    int j;
    j          = 0;
    cand_found = 1'b0;
    cand_idx   = '0;
    for (int k = 0; k < N_REDUCER; k++) begin
      j = (int'(search_start) + k) % N_REDUCER;
      if (!cand_found && cand_mask[j]) begin
        cand_found = 1'b1;
        cand_idx   = RW'(j);
      end
    end
  end

  // Dispatch path: one-cycle init strobe plus configuration bus that holds
  // the last dispatched payload.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      red_init       <= '0;
      conf_patch_num <= '0;
      conf_row       <= '0;
      conf_col       <= '0;
      conf_sum       <= '0;
    end else begin
      red_init <= disp_mask;
      if (dispatch) begin
        conf_patch_num <= req_patch_num;
        conf_row       <= req_row;
        conf_col       <= req_col;
        conf_sum       <= req_sum;
      end
    end
  end

  // Per-reducer bookkeeping and the round-robin pointer.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      owned   <= '0;
      pending <= '0;
      rr      <= '0;
    end else begin
      owned   <= (owned & ~ack_mask) | disp_mask;
      pending <= (pending & ~ack_mask) | red_done;
      if (ack) rr <= ack_next_idx;
    end
  end

  // Result register: loads whenever empty or being drained, and holds its
  // payload untouched while waiting for an ack.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      res_valid     <= 1'b0;
      res_idx       <= '0;
      res_patch_num <= '0;
      res_sum       <= '0;
    end else if (load) begin
      res_valid <= cand_found;
      if (cand_found) begin
        res_idx       <= cand_idx;
        res_patch_num <= red_patch_num[int'(cand_idx)*PW +: PW];
        res_sum       <= red_sum[int'(cand_idx)*FP_SIZE +: FP_SIZE];
      end
    end
  end

`ifdef DISPATCH_LATE_DROP_EN
  assign late = (req_row < cur_row);

  // Late requests are consumed without an init; the count saturates.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      n_late <= '0;
    end else if (accept && late && (n_late != 16'hFFFF)) begin
      n_late <= n_late + 16'd1;
    end
  end
`else
  logic [N_ROW_SIZE-1:0] unused_cur_row;
  assign unused_cur_row = cur_row;
  assign late           = 1'b0;
  assign n_late         = '0;
`endif

endmodule

// File: tb/tb_patch_reducer_dispatcher.sv
// tb_patch_reducer_dispatcher
//
// Self-checking bench for patch_reducer_dispatcher. A behavioural model of
// the reducer pool bookkeeping (arrays of owned/pending flags, a result slot
// and a pointer) predicts every output cycle by cycle; directed scenarios are
// followed by a randomized phase.

module tb_patch_reducer_dispatcher;

  localparam int NR = 4;
  localparam int PW = 4;

`ifdef DISPATCH_LATE_DROP_EN
  localparam bit LATE_EN = 1'b1;
`else
  localparam bit LATE_EN = 1'b0;
`endif

  logic          CLK;
  logic          RESET;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_patch_num;
  logic [10:0]   req_row;
  logic [10:0]   req_col;
  logic [31:0]   req_sum;
  logic [10:0]   cur_row;
  logic [3:0]    red_available;
  logic [3:0]    red_done;
  logic [15:0]   red_patch_num;
  logic [127:0]  red_sum;
  logic [3:0]    red_init;
  logic [3:0]    conf_patch_num;
  logic [10:0]   conf_row;
  logic [10:0]   conf_col;
  logic [31:0]   conf_sum;
  logic          res_valid;
  logic          res_ack;
  logic [3:0]    res_patch_num;
  logic [31:0]   res_sum;
  logic [15:0]   n_late;
  logic          busy;

  patch_reducer_dispatcher dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_patch_num(req_patch_num), .req_row(req_row), .req_col(req_col), .req_sum(req_sum),
    .cur_row(cur_row), .red_available(red_available), .red_done(red_done),
    .red_patch_num(red_patch_num), .red_sum(red_sum), .red_init(red_init),
    .conf_patch_num(conf_patch_num), .conf_row(conf_row), .conf_col(conf_col), .conf_sum(conf_sum),
    .res_valid(res_valid), .res_ack(res_ack), .res_patch_num(res_patch_num), .res_sum(res_sum),
    .n_late(n_late), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  bit          m_owned [NR];
  bit          m_pend  [NR];
  int          m_rr;
  int          m_nlate;
  bit          m_rv;
  int          m_ridx;
  logic [3:0]  m_rpn;
  logic [31:0] m_rsum;
  logic [3:0]  m_init;
  logic [3:0]  m_cpn;
  logic [10:0] m_crow;
  logic [10:0] m_ccol;
  logic [31:0] m_csum;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check req_ready mid-cycle, advance the model on the current
  // inputs, then check registered outputs just after the edge.
  task automatic applyStimulus();
    bit exp_ready, accept, late, ack, found;
    int disp, start, j, ack_idx;
    @(negedge CLK);
    exp_ready = 1'b0;
    disp      = -1;
    for (int i = 0; i < NR; i++) begin
      if (red_available[i] && !m_owned[i]) begin
        exp_ready = 1'b1;
        if (disp < 0) disp = i;
      end
    end
    checkOutput("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});

    if (RESET) begin
      for (int i = 0; i < NR; i++) begin
        m_owned[i] = 1'b0;
        m_pend[i]  = 1'b0;
      end
      m_rr = 0; m_nlate = 0; m_rv = 1'b0; m_ridx = 0;
      m_rpn = '0; m_rsum = '0; m_init = '0;
      m_cpn = '0; m_crow = '0; m_ccol = '0; m_csum = '0;
    end else begin
      accept  = req_valid && exp_ready;
      late    = LATE_EN && (req_row < cur_row);
      ack     = m_rv && res_ack;
      ack_idx = m_ridx;
      m_init  = '0;
      if (accept && !late) begin
        m_init = 4'(1 << disp);
        m_cpn = req_patch_num; m_crow = req_row; m_ccol = req_col; m_csum = req_sum;
      end
      if (accept && late && m_nlate < 65535) m_nlate++;
      if (!m_rv || ack) begin
        start = ack ? (ack_idx + 1) % NR : m_rr;
        found = 1'b0;
        for (int k = 0; k < NR; k++) begin
          j = (start + k) % NR;
          if (!found && m_pend[j] && !(ack && j == ack_idx)) begin
            found  = 1'b1;
            m_ridx = j;
            m_rpn  = red_patch_num[j*PW +: PW];
            m_rsum = red_sum[j*32 +: 32];
          end
        end
        m_rv = found;
      end
      if (ack) begin
        m_pend[ack_idx]  = 1'b0;
        m_owned[ack_idx] = 1'b0;
        m_rr = (ack_idx + 1) % NR;
      end
      if (accept && !late) m_owned[disp] = 1'b1;
      for (int i = 0; i < NR; i++) if (red_done[i]) m_pend[i] = 1'b1;
    end

    @(posedge CLK);
    #1;
    checkOutput("red_init", {28'd0, red_init}, {28'd0, m_init});
    checkOutput("res_valid", {31'd0, res_valid}, {31'd0, m_rv});
    checkOutput("n_late", {16'd0, n_late}, m_nlate[31:0]);
    checkOutput("busy", {31'd0, busy},
                {31'd0, (m_rv || m_owned[0] || m_owned[1] || m_owned[2] || m_owned[3])});
    checkOutput("conf_patch_num", {28'd0, conf_patch_num}, {28'd0, m_cpn});
    checkOutput("conf_row", {21'd0, conf_row}, {21'd0, m_crow});
    checkOutput("conf_col", {21'd0, conf_col}, {21'd0, m_ccol});
    checkOutput("conf_sum", conf_sum, m_csum);
    if (m_rv) begin
      checkOutput("res_patch_num", {28'd0, res_patch_num}, {28'd0, m_rpn});
      checkOutput("res_sum", res_sum, m_rsum);
    end
  endtask

  logic [31:0] fsum [NR];

  initial begin
    fsum[0] = 32'h3F800000;
    fsum[1] = 32'h40000000;
    fsum[2] = 32'h40400000;
    fsum[3] = 32'h40800000;

    RESET = 1'b1; req_valid = 1'b0; req_patch_num = '0; req_row = '0; req_col = '0;
    req_sum = '0; cur_row = '0; red_available = 4'b1111; red_done = '0;
    red_patch_num = '0; red_sum = '0; res_ack = 1'b0;
    for (int i = 0; i < NR; i++) begin
      m_owned[i] = 1'b0;
      m_pend[i]  = 1'b0;
    end
    m_rr = 0; m_nlate = 0; m_rv = 1'b0; m_ridx = 0; m_rpn = '0; m_rsum = '0;
    m_init = '0; m_cpn = '0; m_crow = '0; m_ccol = '0; m_csum = '0;

    // Reset held three cycles
    repeat (3) applyStimulus();
    RESET = 1'b0;
    checkOutput("reset_res_sum", res_sum, 32'd0);
    checkOutput("reset_res_pn", {28'd0, res_patch_num}, 32'd0);

    // Back-to-back dispatch to all four reducers, lowest index first
    for (int i = 0; i < NR; i++) begin
      req_valid = 1'b1; req_patch_num = 4'(i); req_row = 11'd5;
      req_col = 11'($urandom); req_sum = $urandom;
      applyStimulus();
      checkOutput("dispatch_order", {28'd0, red_init}, 32'(1 << i));
    end
    req_patch_num = 4'd4;
    applyStimulus();
    checkOutput("fifth_not_ready", {31'd0, req_ready}, 32'd0);

    // All reducers finish together; result held while not acked, and the
    // still-available reducers are not re-initialised
    req_valid = 1'b0;
    red_available = 4'b0000;
    for (int i = 0; i < NR; i++) begin
      red_patch_num[i*PW +: PW] = 4'(i);
      red_sum[i*32 +: 32] = fsum[i];
    end
    red_done = 4'b1111;
    applyStimulus();
    red_done = 4'b0000;
    red_available = 4'b1111;
    req_valid = 1'b1; req_patch_num = 4'd9; req_row = 11'd7;
    repeat (10) applyStimulus();
    checkOutput("held_sum", res_sum, fsum[0]);
    req_valid = 1'b0;

    // Round-robin drain, one result per cycle
    res_ack = 1'b1;
    for (int i = 1; i < NR; i++) begin
      applyStimulus();
      checkOutput("drain_sum", res_sum, fsum[i]);
    end
    applyStimulus();
    res_ack = 1'b0;
    checkOutput("drained_busy", {31'd0, busy}, 32'd0);

    // Late request, then the same request once no longer late
    cur_row = 11'd9; req_valid = 1'b1; req_row = 11'd8; req_patch_num = 4'd6;
    req_col = 11'd3; req_sum = 32'h12345678;
    applyStimulus();
    cur_row = 11'd8;
    applyStimulus();
    req_valid = 1'b0;
    applyStimulus();

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      req_valid     = 1'($urandom);
      req_patch_num = 4'($urandom);
      req_row       = 11'($urandom_range(0, 7));
      cur_row       = 11'($urandom_range(0, 7));
      req_col       = 11'($urandom);
      req_sum       = $urandom;
      red_available = 4'($urandom);
      res_ack       = ($urandom_range(0, 3) != 0);
      red_done      = '0;
      for (int i = 0; i < NR; i++) begin
        if (m_owned[i] && !m_pend[i] && ($urandom_range(0, 2) == 0)) begin
          red_done[i] = 1'b1;
          red_patch_num[i*PW +: PW] = 4'($urandom);
          red_sum[i*32 +: 32] = $urandom;
        end
      end
      applyStimulus();
    end
    red_done = '0; res_ack = 1'b0; req_valid = 1'b0;

    // Reset one cycle after a dispatch
    RESET = 1'b1;
    applyStimulus();
    RESET = 1'b0; red_available = 4'b1111; req_valid = 1'b1; req_row = 11'd5; cur_row = 11'd0;
    applyStimulus();
    req_valid = 1'b0; RESET = 1'b1;
    applyStimulus();
    checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
    RESET = 1'b0; red_available = 4'b0101;
    applyStimulus();
    red_available = 4'b0000;
    applyStimulus();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
